// File: rtl/alu_io_pkg.sv
// Shared constants for the ALU operand loader: entry stage encoding and default widths.
package alu_io_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_F     = 2'd2,
        S_ISSUE = 2'd3
    } stage_e;

endpackage

// File: rtl/alu_operand_loader_btn_debounce.sv
// Pushbutton conditioning: 2-flop synchroniser, mismatch-count debounce, and a
// one-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic enter
);

    localparam int CW = $clog2(DB_CYCLES);

    logic          btn_meta_q, btn_meta_d;
    logic          btn_s_q, btn_s_d;
    logic          db_q, db_d;
    logic          db_dly_q, db_dly_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        btn_meta_d = btn_raw;
        btn_s_d    = btn_meta_q;
        db_d       = db_q;
        db_dly_d   = db_q;
        cnt_d      = '0;
        // Any sample that agrees with the debounced level restarts the count.
        if (btn_s_q != db_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                db_d = btn_s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            db_q       <= 1'b0;
            db_dly_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_s_q    <= btn_s_d;
            db_q       <= db_d;
            db_dly_q   <= db_dly_d;
            cnt_q      <= cnt_d;
        end
    end

    assign enter = db_q & ~db_dly_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Collects A, B and F from the switches one enter-press at a time and hands the
// ALU the whole triple at once, with a one-cycle issue strobe.
module alu_operand_loader
    import alu_io_pkg::*;
#(
    parameter int W         = W_DEFAULT,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     sw,
    input  logic             btn_enter,
    input  logic             clr,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    output logic [W-1:0]     f,
    output logic             issue,
    output logic [1:0]       stage,
    output logic [CNT_W-1:0] op_count
);

    logic             enter;
    logic [W-1:0]     sw_meta_q, sw_meta_d, sw_s_q, sw_s_d;
    logic             clr_meta_q, clr_meta_d, clr_s_q, clr_s_d;
    stage_e           state_q, state_d;
    logic [W-1:0]     a_sh_q, a_sh_d, b_sh_q, b_sh_d, f_sh_q, f_sh_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, f_q, f_d;
    logic             issue_q, issue_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_enter),
        .enter   (enter)
    );

    // issue is a bare strobe with no back-pressure: the ALU consumes a/b/f in
    // the cycle issue is high, and they then hold until the next issue.
    always_comb begin
        sw_meta_d  = sw;
        sw_s_d     = sw_meta_q;
        clr_meta_d = clr;
        clr_s_d    = clr_meta_q;
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        f_sh_d     = f_sh_q;
        a_d        = a_q;
        b_d        = b_q;
        f_d        = f_q;
        issue_d    = 1'b0;
        cnt_d      = cnt_q;
        case (state_q)
            S_A, S_B, S_F: begin
                if (clr_s_q) begin
                    state_d = S_A;
                    a_sh_d  = '0;
                    b_sh_d  = '0;
                    f_sh_d  = '0;
                end else if (enter) begin
                    case (state_q)
                        S_A:     begin a_sh_d = sw_s_q; state_d = S_B;     end
                        S_B:     begin b_sh_d = sw_s_q; state_d = S_F;     end
                        default: begin f_sh_d = sw_s_q; state_d = S_ISSUE; end
                    endcase
                end
            end
            S_ISSUE: begin
                a_d     = a_sh_q;
                b_d     = b_sh_q;
                f_d     = f_sh_q;
                issue_d = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = S_A;
            end
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
            clr_meta_q <= 1'b0;
            clr_s_q    <= 1'b0;
            state_q    <= S_A;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            f_sh_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            f_q        <= '0;
            issue_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sw_meta_q  <= sw_meta_d;
            sw_s_q     <= sw_s_d;
            clr_meta_q <= clr_meta_d;
            clr_s_q    <= clr_s_d;
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            f_sh_q     <= f_sh_d;
            a_q        <= a_d;
            b_q        <= b_d;
            f_q        <= f_d;
            issue_q    <= issue_d;
            cnt_q      <= cnt_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign f        = f_q;
    assign issue    = issue_q;
    assign stage    = state_q;
    assign op_count = cnt_q;

endmodule
